// File: rtl/local_mem_arb_if.sv
// local_mem_arb_if -- bundle of requester, shared-response and memory-side
// signals for local_mem_arb.
//   m0_*/m1_*   : per-requester req/we/lock/addr/wdata in, gnt/rvalid out
//   rdata       : registered read data shared by both requesters
//   mem_*       : memory addr/we/write data out, combinational read data in
//   err         : sticky out-of-range flag
// Modports: slave = arbiter side, master = requesters + memory side.
interface local_mem_arb_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  m0_req;
  logic                  m1_req;
  logic                  m0_we;
  logic                  m1_we;
  logic                  m0_lock;
  logic                  m1_lock;
  logic [31:0]           m0_addr;
  logic [31:0]           m1_addr;
  logic [DATA_WIDTH-1:0] m0_wdata;
  logic [DATA_WIDTH-1:0] m1_wdata;
  logic                  m0_gnt;
  logic                  m1_gnt;
  logic                  m0_rvalid;
  logic                  m1_rvalid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [31:0]           mem_addr;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_wr_data;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic                  err;

  modport slave (
    input  m0_req, m1_req, m0_we, m1_we, m0_lock, m1_lock,
           m0_addr, m1_addr, m0_wdata, m1_wdata, mem_rd_data,
    output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, rdata,
           mem_addr, mem_we, mem_wr_data, err
  );

  modport master (
    output m0_req, m1_req, m0_we, m1_we, m0_lock, m1_lock,
           m0_addr, m1_addr, m0_wdata, m1_wdata, mem_rd_data,
    input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, rdata,
           mem_addr, mem_we, mem_wr_data, err
  );
endinterface

// File: rtl/local_mem_arb.sv
// local_mem_arb -- two-requester arbiter in front of a single-port local
// memory with combinational read data. Round-robin on ties, with an
// optional lock that lets the owner keep the memory across accesses.
// Ports:
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : local_mem_arb_if.slave (requester, response and memory signals)
// Build option: define LOCAL_MEM_ARB_BOUND_CHECK_EN to suppress accesses with
// addr >= DEPTH (no write, reads return 0) and set the sticky err flag.
//
// state | meaning
// IDLE  | no owner, memory outputs parked at 0
// OWN0  | requester 0 owns the memory this cycle
// OWN1  | requester 1 owns the memory this cycle
module local_mem_arb #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256
) (
  input logic           clk,
  input logic           rst_n,
  local_mem_arb_if.slave bus
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t                state;
  state_t                state_nxt;
  logic                  last_served;
  logic                  last_served_nxt;
  logic                  gnt0;
  logic                  gnt1;
  logic                  rd_fire;
  logic                  oob_acc;
  logic [31:0]           mem_addr_c;
  logic                  mem_we_c;
  logic [DATA_WIDTH-1:0] mem_wd_c;
  logic [DATA_WIDTH-1:0] rd_capture;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rvalid0_q;
  logic                  rvalid1_q;

  if (DEPTH < 1) begin : g_bad_depth
    $error("local_mem_arb: DEPTH must be at least 1");
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Tie-break uses last_served as it will be after this edge, so an
  // access granted in this very cycle already counts; otherwise two
  // contending unlocked requesters would not alternate.
  assign last_served_nxt = gnt0 ? 1'b0 : (gnt1 ? 1'b1 : last_served);

  always_comb begin
    state_nxt = IDLE;
    if (state == OWN0 && bus.m0_req && bus.m0_lock)      state_nxt = OWN0;
    else if (state == OWN1 && bus.m1_req && bus.m1_lock) state_nxt = OWN1;
    else if (bus.m0_req && bus.m1_req)                   state_nxt = last_served_nxt ? OWN0 : OWN1;
    else if (bus.m0_req)                                 state_nxt = OWN0;
    else if (bus.m1_req)                                 state_nxt = OWN1;
  end

  always_comb begin
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    mem_addr_c = '0;
    mem_wd_c   = '0;
    mem_we_c   = 1'b0;
    unique case (state)
      OWN0: begin
        gnt0       = bus.m0_req;
        mem_addr_c = bus.m0_addr;
        mem_wd_c   = bus.m0_wdata;
        mem_we_c   = bus.m0_we & bus.m0_req;
      end
      OWN1: begin
        gnt1       = bus.m1_req;
        mem_addr_c = bus.m1_addr;
        mem_wd_c   = bus.m1_wdata;
        mem_we_c   = bus.m1_we & bus.m1_req;
      end
      default: ;
    endcase
    if (oob_acc) begin
      mem_we_c   = 1'b0;
      mem_addr_c = '0;
    end
  end

  assign rd_fire = (gnt0 & ~bus.m0_we) | (gnt1 & ~bus.m1_we);

`ifdef LOCAL_MEM_ARB_BOUND_CHECK_EN
  logic err_q;

  assign oob_acc = ((state == OWN0) && bus.m0_req && (bus.m0_addr >= 32'(DEPTH))) ||
                   ((state == OWN1) && bus.m1_req && (bus.m1_addr >= 32'(DEPTH)));
  assign rd_capture = oob_acc ? '0 : bus.mem_rd_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err_q <= 1'b0;
    else if (oob_acc) err_q <= 1'b1;
  end

  assign bus.err = err_q;
`else
  assign oob_acc    = 1'b0;
  assign rd_capture = bus.mem_rd_data;
  assign bus.err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_served <= 1'b1;
      rdata_q     <= '0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
    end else begin
      last_served <= last_served_nxt;
      rvalid0_q   <= gnt0 & ~bus.m0_we;
      rvalid1_q   <= gnt1 & ~bus.m1_we;
      if (rd_fire) rdata_q <= rd_capture;
    end
  end

  assign bus.m0_gnt      = gnt0;
  assign bus.m1_gnt      = gnt1;
  assign bus.mem_addr    = mem_addr_c;
  assign bus.mem_we      = mem_we_c;
  assign bus.mem_wr_data = mem_wd_c;
  assign bus.rdata       = rdata_q;
  assign bus.m0_rvalid   = rvalid0_q;
  assign bus.m1_rvalid   = rvalid1_q;

endmodule

// File: doc/local_mem_arb.md
LOCAL_MEM_ARB -- requirements
Module: local_mem_arb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: word width of the local memory.
REQ-002 SHALL have parameter DEPTH, default 256: number of words in the local memory.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have ports m0_req / m1_req, input, 1: requester k holds a transaction.
REQ-006 SHALL have ports m0_we / m1_we, input, 1: 1 = write, 0 = read.
REQ-007 SHALL have ports m0_lock / m1_lock, input, 1: the owner keeps the grant after the current access.
REQ-008 SHALL have ports m0_addr / m1_addr, input, 32: word address.
REQ-009 SHALL have ports m0_wdata / m1_wdata, input, DATA_WIDTH: write data.
REQ-010 SHALL have ports m0_gnt / m1_gnt, output, 1: access performed this cycle.
REQ-011 SHALL have ports m0_rvalid / m1_rvalid, output, 1: read data valid this cycle.
REQ-012 SHALL have port rdata, output, DATA_WIDTH: registered read data shared by both requesters.
REQ-013 SHALL have port mem_addr, output, 32: to the memory addr input.
REQ-014 SHALL have port mem_we, output, 1: to the memory write enable.
REQ-015 SHALL have port mem_wr_data, output, DATA_WIDTH: to the memory write data.
REQ-016 SHALL have port mem_rd_data, input, DATA_WIDTH: combinational read data from the memory.
REQ-017 SHALL have port err, output, 1: sticky out-of-range flag (see Configuration).

Function
REQ-018 SHALL implement the FSM states IDLE, OWN0 and OWN1, held in a register.
REQ-019 SHALL compute the next state at every edge as follows.
- Current owner k with mk_req=1 and mk_lock=1: stay OWNk.
- Otherwise both requesting: go to the requester not equal to last_served.
- Otherwise exactly one requesting: go to that requester.
- Otherwise: go to IDLE.
REQ-020 SHALL, in OWNk, drive mem_addr=mk_addr, mem_wr_data=mk_wdata, mem_we=mk_we&mk_req and mk_gnt=mk_req, all combinationally from the state register.
REQ-021 SHALL, in IDLE, drive mem_addr=0, mem_wr_data=0, mem_we=0 and both gnt=0.
REQ-022 SHALL commit a write at the edge ending a cycle with mk_gnt=1 and mk_we=1.
REQ-023 SHALL capture mem_rd_data into rdata at the edge ending a cycle with mk_gnt=1 and mk_we=0, and assert mk_rvalid for exactly the following cycle.
REQ-024 SHALL give latency of 1 cycle from req rise to gnt and 2 cycles to rvalid.
REQ-025 SHALL sustain one access per cycle for a locked owner, or for the same sole requester.
REQ-026 SHALL hold rdata unchanged when no read completes.
REQ-027 SHALL update last_served to k at each edge ending a cycle with mk_gnt=1.
REQ-028 SHALL, when an unlocked owner and the other requester both request, alternate grants so that no requester waits more than 1 access.
REQ-029 SHALL ensure a locked owner blocks the other requester indefinitely; the requester must drop lock to release.
REQ-030 SHALL require requesters to hold req, we, addr and wdata stable until gnt is sampled high; dropping req before gnt cancels the request with no memory effect.

Reset
REQ-031 SHALL, on rst_n=0, immediately force: state IDLE, last_served=1 (m0 wins the first tie), rdata=0, rvalid=0, gnt=0, mem_we=0, err=0.
REQ-032 SHALL ensure a reset asserted during an OWNk cycle suppresses that access: no write and no rvalid.
REQ-033 SHALL, after rst_n deassertion, grant no earlier than the first edge with rst_n=1.

Configuration
REQ-034 SHALL, with macro LOCAL_MEM_ARB_BOUND_CHECK_EN defined, treat any granted access with mk_addr >= DEPTH as follows.
- Force mem_we=0 and mem_addr=0.
- A read returns rdata=0 with rvalid still asserted.
- err is set and held until reset.
REQ-035 SHALL, without LOCAL_MEM_ARB_BOUND_CHECK_EN, tie err to 0 and pass addresses unchecked.

Verification
REQ-036 SHALL cover sole write then read: m0 writes 0x55 to addr 3; m0 reads addr 3 -> gnt 1 cycle after req, m0_rvalid 2 cycles after req, rdata=0x55.
REQ-037 SHALL cover a simultaneous first request: m0 and m1 both read from reset -> m0 granted first, m1 next cycle, m1_rvalid one cycle after m1_gnt.
REQ-038 SHALL cover lock: m0_lock=1 for 4 reads while m1_req=1 -> four consecutive m0_gnt, then m1_gnt on the cycle after m0 drops lock.
REQ-039 SHALL cover reset mid-access: rst_n=0 during an OWN1 write of 0xAA to addr 7 -> mem_we=0 immediately, addr 7 unchanged, all outputs at reset values.
REQ-040 SHALL cover bounds check (macro defined): m1 writes addr DEPTH -> memory unchanged, err=1 and stays 1; a read of addr DEPTH+5 returns rdata=0.
REQ-041 SHALL cover round-robin: both requesting unlocked for 6 cycles -> grants alternate m0, m1, m0, m1, m0, m1.
